// File: rtl/regfile_pkg.sv
// Shared types for the register file: clear-engine state encoding and depth derivation.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps every register address once, one per cycle, then returns idle.
//
//   state    | meaning
//   ST_IDLE  | normal operation, waiting for a clear request
//   ST_CLEAR | zeroing register/pending bit at cnt_q, Busy asserted
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req_i,
    output logic              busy_o,
    output logic              clear_en_o,
    output logic [ADDR_W-1:0] clear_addr_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Requests here are ignored; the counter wraps to 0 on the last address.
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o       = (state_q == ST_CLEAR);
    assign clear_en_o   = busy_o;
    assign clear_addr_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-through bypass, pending-write scoreboard
// and a sequential bulk-clear engine.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Reg_Write_i,
    input  logic [ADDR_W-1:0]        Write_Register_i,
    input  logic [DATA_W-1:0]        Write_Data_i,
    input  logic [N_RD*ADDR_W-1:0]   Read_Register_i,
    output logic [N_RD*DATA_W-1:0]   Read_Data_o,
    output logic [N_RD-1:0]          Pending_o,
    input  logic                     Reserve_i,
    input  logic [ADDR_W-1:0]        Reserve_Register_i,
    input  logic                     Clear_Req_i,
    output logic                     Busy_o
);

    localparam int DEPTH     = int'(depth_of(ADDR_W));
    localparam bit HARD_ZERO = (ZERO_REG != 0);

    logic              clear_en;
    logic [ADDR_W-1:0] clear_addr;
    logic              wr_ok;
    logic              rsv_ok;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk          (clk),
        .reset        (reset),
        .clear_req_i  (Clear_Req_i),
        .busy_o       (Busy_o),
        .clear_en_o   (clear_en),
        .clear_addr_o (clear_addr)
    );

    // Reset gates the bypass so outputs read zero while reset is held.
    assign wr_ok  = Reg_Write_i & ~Busy_o & ~reset
                  & ~(HARD_ZERO & (Write_Register_i == '0));
    assign rsv_ok = Reserve_i & ~Busy_o
                  & ~(HARD_ZERO & (Reserve_Register_i == '0));

    // Reserve is applied after the write-clear so a same-cycle reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (clear_en) begin
            pend_d[clear_addr] = 1'b0;
        end else begin
            if (wr_ok) begin
                pend_d[Write_Register_i] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[Reserve_Register_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (clear_en) begin
                regs_q[clear_addr] <= '0;
            end else if (wr_ok) begin
                regs_q[Write_Register_i] <= Write_Data_i;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic              byp;

        assign rd_addr = Read_Register_i[k*ADDR_W +: ADDR_W];
        assign byp     = wr_ok && (Write_Register_i == rd_addr);

        assign Read_Data_o[k*DATA_W +: DATA_W] =
            (HARD_ZERO && (rd_addr == '0)) ? '0 :
            byp                            ? Write_Data_i :
                                             regs_q[rd_addr];
        assign Pending_o[k] = pend_q[rd_addr] & ~byp;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port register file for the MIPS datapath, generalising the fixed 32x32 two-read-port file. Adds a configurable read-port count, a hardwired-zero register 0, same-cycle write-through bypass, a per-register pending-write scoreboard for hazard detection, and a sequential bulk-clear engine. Sits between the decode stage, which issues reads and reservations, and the writeback stage, which issues writes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never pending

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Reg_Write_i  in  1  write enable
- Write_Register_i  in  ADDR_W  write address
- Write_Data_i  in  DATA_W  write data
- Read_Register_i  in  N_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- Read_Data_o  out  N_RD*DATA_W  packed read data, combinational
- Pending_o  out  N_RD  per-port flag: addressed register awaits an outstanding write
- Reserve_i  in  1  mark Reserve_Register_i as pending
- Reserve_Register_i  in  ADDR_W  register to reserve
- Clear_Req_i  in  1  request bulk clear of all registers and scoreboard
- Busy_o  out  1  clear engine active; writes and reserves are dropped

## Operation
- Reset is asynchronous and active-high: all registers, pending bits and the clear counter go to 0; FSM goes to IDLE; Busy_o = 0; Read_Data_o = 0; Pending_o = 0.
- Write: when Reg_Write_i is high and Busy_o is low, Write_Data_i is stored at the rising edge. With ZERO_REG = 1, writes to address 0 are discarded.
- Read port k: Read_Data_o[k] = Write_Data_i if Reg_Write_i is high, Busy_o is low, the addresses match and the address is not a discarded address 0; otherwise it is the stored value. Address 0 reads 0 when ZERO_REG = 1.
- Scoreboard, one bit per register:
  - Reserve_i sets the bit at the edge.
  - An accepted write clears the bit at the edge.
  - Reserve and write to the same address in the same cycle leave the bit set (reserve wins).
  - Reserve of address 0 is ignored when ZERO_REG = 1.
  - Pending_o[k] = pend[addr_k] & ~(accepted write to addr_k this cycle). A reserve is not visible until the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on Clear_Req_i; the counter loads 0.
  - In CLEAR, each cycle register[cnt] <= 0 and pend[cnt] <= 0, then cnt increments.
  - CLEAR -> IDLE after the cycle with cnt = DEPTH-1. The counter is ADDR_W bits wide and wraps to 0.
  - Busy_o = (state == CLEAR).
  - Clear_Req_i asserted during CLEAR is ignored, with no restart.
  - Reads during CLEAR return current contents: registers below cnt are already 0, others are not yet cleared. No bypass is applied.
- Reset asserted mid-clear aborts the clear immediately to the reset state.

## Timing
- Read latency is 0 cycles (combinational). Write to a new read value takes 1 edge; bypass gives the same-cycle view.
- Clear occupies exactly DEPTH cycles, with Busy_o high on edges 1..DEPTH after the request edge. Writes and reserves may resume in the first cycle Busy_o is low.
- Pending_o is combinational from the stored bits plus the same-cycle write.

## Structure
- Shared package/header `regfile_pkg`: FSM state encodings (IDLE = 1'b0, CLEAR = 1'b1) and the DEPTH derivation macro.
- Sub-module `regfile_clear_fsm`: FSM, counter and Busy_o. It exports clear_en and clear_addr to the array and scoreboard logic.
- Read ports are built in a generate loop over N_RD.

## Test plan
- Reset: assert reset mid-cycle, asynchronously -> all Read_Data_o = 0, Pending_o = 0 and Busy_o = 0 before the next edge.
- Write/read and bypass: write 0xDEADBEEF to r5 while port 0 reads r5 -> port 0 shows 0xDEADBEEF the same cycle, and still shows it after the edge once Reg_Write_i = 0.
- Zero register: write 0x12345678 to r0 and reserve r0 -> r0 reads 0 and Pending_o stays 0.
- Scoreboard:
  - Reserve r7 -> Pending_o = 1 on the next cycle.
  - Write r7 -> Pending_o = 0 in that same cycle.
  - Reserve and write r9 together -> r9 is pending next cycle and holds the written data.
- Clear:
  - Fill r1..r31 with nonzero values and pulse Clear_Req_i -> Busy_o is high for 32 cycles.
  - A write to r3 during the clear is dropped.
  - A second Clear_Req_i during the clear is ignored.
  - Afterwards all registers read 0 and no register is pending.
- Reset mid-clear: assert reset at cycle 10 of CLEAR -> Busy_o = 0 immediately, and all registers read 0.
